// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM arbiter: FSM states, owner ids and
// the legal range of the settle interval.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_LOAD  = 1'b1;

  localparam int WAIT_CYCLES_MIN = 2;
  localparam int WAIT_CYCLES_MAX = 15;

  // Out-of-range settle intervals are pinned to the nearest legal value.
  function automatic logic [3:0] clamp_wait(input int w);
    if (w < WAIT_CYCLES_MIN) return 4'(WAIT_CYCLES_MIN);
    if (w > WAIT_CYCLES_MAX) return 4'(WAIT_CYCLES_MAX);
    return 4'(w);
  endfunction

endpackage

// File: rtl/rom_ready_sync.sv
// Two-flop synchronizer bringing the ROM's asynchronous ready level into clk.
module rom_ready_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/rom_arbiter.sv
// Shares one asynchronous ROM between instruction fetch and data load.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise fetch wins ties.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchAck,
  output logic              fetchValid,
  output logic [31:0]       fetchData,
  input  logic              loadReq,
  input  logic [ADDR_W-1:0] loadAddr,
  output logic              loadAck,
  output logic              loadValid,
  output logic [31:0]       loadData,
  output logic [ADDR_W-1:0] romAddr,
  output logic              romTrigger,
  input  logic [31:0]       romData,
  input  logic              romReady
);

  localparam logic [3:0] WAIT_LOAD = clamp_wait(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              trig_q, trig_d;
  logic [31:0]       fdata_q, fdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              fvalid_q, fvalid_d;
  logic              lvalid_q, lvalid_d;

  logic ready_sync;
  logic accept_slot;
  logic grant_any;
  logic grant_load;

  rom_ready_sync u_ready_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (romReady),
    .sync_o  (ready_sync)
  );

  // CAPTURE doubles as an accept slot so a new request overlaps the Valid cycle.
  assign accept_slot = rst_n && ((state_q == IDLE) || (state_q == CAPTURE));
  assign grant_any   = accept_slot && (fetchReq || loadReq);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // rr_q names the requester that wins the next tie.
  assign grant_load = loadReq && (!fetchReq || (rr_q == OWNER_LOAD));

  always_comb begin
    rr_d = rr_q;
    if (grant_any) rr_d = grant_load ? OWNER_FETCH : OWNER_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= OWNER_FETCH;
    else        rr_q <= rr_d;
  end
`else
  assign grant_load = loadReq && !fetchReq;
`endif

  assign fetchAck = grant_any && !grant_load;
  assign loadAck  = grant_any && grant_load;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    trig_d   = trig_q;
    fdata_d  = fdata_q;
    ldata_d  = ldata_q;
    fvalid_d = 1'b0;
    lvalid_d = 1'b0;
    case (state_q)
      IDLE, CAPTURE: begin
        if (grant_any) begin
          addr_d  = grant_load ? loadAddr : fetchAddr;
          owner_d = grant_load ? OWNER_LOAD : OWNER_FETCH;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        trig_d  = ~trig_q;
        cnt_d   = WAIT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (ready_sync) begin
          if (owner_q == OWNER_LOAD) begin
            ldata_d  = romData;
            lvalid_d = 1'b1;
          end else begin
            fdata_d  = romData;
            fvalid_d = 1'b1;
          end
          state_d = CAPTURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      owner_q  <= OWNER_FETCH;
      addr_q   <= '0;
      trig_q   <= 1'b0;
      fdata_q  <= 32'd0;
      ldata_q  <= 32'd0;
      fvalid_q <= 1'b0;
      lvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      trig_q   <= trig_d;
      fdata_q  <= fdata_d;
      ldata_q  <= ldata_d;
      fvalid_q <= fvalid_d;
      lvalid_q <= lvalid_d;
    end
  end

  assign romAddr    = addr_q;
  assign romTrigger = trig_q;
  assign fetchData  = fdata_q;
  assign loadData   = ldata_q;
  assign fetchValid = fvalid_q;
  assign loadValid  = lvalid_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with an asynchronous ROM model and trigger/address monitors.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetchReq = 1'b0;
  logic [31:0] fetchAddr = 32'd0;
  logic        fetchAck, fetchValid;
  logic [31:0] fetchData;
  logic        loadReq = 1'b0;
  logic [31:0] loadAddr = 32'd0;
  logic        loadAck, loadValid;
  logic [31:0] loadData;
  logic [31:0] romAddr;
  logic        romTrigger;
  logic [31:0] romData;
  logic        romReady = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A00001;
    return 32'h5A000001 ^ (a * 32'h00010101);
  endfunction

  assign romData = rom_word(romAddr);

  rom_arbiter #(.WAIT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchAck(fetchAck),
    .fetchValid(fetchValid), .fetchData(fetchData),
    .loadReq(loadReq), .loadAddr(loadAddr), .loadAck(loadAck),
    .loadValid(loadValid), .loadData(loadData),
    .romAddr(romAddr), .romTrigger(romTrigger),
    .romData(romData), .romReady(romReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitors: trigger toggles, accepts, valids, and romAddr stability while in flight.
  logic        rst_s = 1'b0;
  logic        trig_prev = 1'b0;
  logic        inflight = 1'b0;
  logic [31:0] tog_addr = 32'd0;
  int          toggle_cnt = 0, ack_cnt = 0, addr_err = 0, fvalid_cnt = 0, lvalid_cnt = 0;
  logic [31:0] lv_data[$];

  always @(posedge clk) rst_s <= rst_n;

  always @(negedge clk) begin
    if (rst_s) begin
      if (fetchAck || loadAck) ack_cnt++;
      if (romTrigger !== trig_prev) begin
        toggle_cnt++;
        inflight = 1'b1;
        tog_addr = romAddr;
      end else if (inflight && romAddr !== tog_addr) begin
        addr_err++;
      end
    end else begin
      inflight = 1'b0;
    end
    if (fetchValid || loadValid) inflight = 1'b0;
    if (fetchValid) fvalid_cnt++;
    if (loadValid) begin
      lvalid_cnt++;
      lv_data.push_back(loadData);
    end
    trig_prev = romTrigger;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit is_load, output int a_cyc, output bit ok);
    ok = 1'b0;
    a_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_load ? loadAck : fetchAck) begin
        ok = 1'b1;
        a_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_valid(input bit is_load, input int bound, output int v_cyc, output bit ok);
    ok = 1'b0;
    v_cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (is_load ? loadValid : fetchValid) begin
        ok = 1'b1;
        v_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic txn(input bit is_load, input logic [31:0] addr, input string tag);
    int a_cyc, v_cyc;
    bit ok_a, ok_v;
    @(posedge clk); #1;
    if (is_load) begin loadReq = 1'b1; loadAddr = addr; end
    else begin fetchReq = 1'b1; fetchAddr = addr; end
    wait_ack(is_load, a_cyc, ok_a);
    check({tag, "_ack"}, 64'(ok_a), 64'd1);
    @(posedge clk); #1;
    fetchReq = 1'b0;
    loadReq = 1'b0;
    wait_valid(is_load, 60, v_cyc, ok_v);
    check({tag, "_valid"}, 64'(ok_v), 64'd1);
    check({tag, "_latency"}, 64'(v_cyc - a_cyc), 64'd7);
    check({tag, "_data"}, 64'(is_load ? loadData : fetchData), 64'(rom_word(addr)));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, n0, r_cyc, v_cyc, a_cyc;
    int acyc[3];
    bit ok;
    bit exp_owner;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({fetchAck, loadAck, fetchValid, loadValid, romTrigger}), 64'd0);
    check("rst_fdata", 64'(fetchData), 64'd0);
    check("rst_ldata", 64'(loadData), 64'd0);
    check("rst_romaddr", 64'(romAddr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single fetch
    t0 = toggle_cnt;
    n0 = lvalid_cnt;
    txn(1'b0, 32'h10, "single");
    check("single_toggles", 64'(toggle_cnt - t0), 64'd1);
    check("single_no_load", 64'(lvalid_cnt - n0), 64'd0);

    // Tie from fresh reset
    do_reset();
    @(posedge clk); #1;
    fetchReq = 1'b1; fetchAddr = 32'h20;
    loadReq = 1'b1;  loadAddr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (fetchAck || loadAck) begin ok = 1'b1; break; end
      end
`ifdef ROM_ARB_ROUND_ROBIN_EN
      exp_owner = (i % 2) == 1;
`else
      exp_owner = 1'b0;
`endif
      check($sformatf("tie_owner%0d", i), 64'({ok, loadAck}), 64'({1'b1, exp_owner}));
    end
    @(posedge clk); #1;
    fetchReq = 1'b0;
    loadReq = 1'b0;
    repeat (12) @(posedge clk);

    // Late ready
    #1 romReady = 1'b0;
    repeat (3) @(posedge clk); #1;
    fetchReq = 1'b1; fetchAddr = 32'h5;
    wait_ack(1'b0, a_cyc, ok);
    check("late_ack", 64'(ok), 64'd1);
    @(posedge clk); #1 fetchReq = 1'b0;
    t0 = toggle_cnt;
    n0 = fvalid_cnt;
    for (int i = 0; i < 10 && toggle_cnt == t0; i++) @(negedge clk);
    check("late_toggle", 64'(toggle_cnt - t0), 64'd1);
    repeat (10) @(posedge clk);
    #1 romReady = 1'b1;
    r_cyc = cyc;
    check("late_no_early_valid", 64'(fvalid_cnt - n0), 64'd0);
    wait_valid(1'b0, 20, v_cyc, ok);
    check("late_valid", 64'(ok), 64'd1);
    check("late_delay", 64'(v_cyc - r_cyc), 64'd3);
    check("late_data", 64'(fetchData), 64'(rom_word(32'h5)));

    // Back-to-back loads
    t0 = toggle_cnt;
    n0 = lv_data.size();
    @(posedge clk); #1;
    loadReq = 1'b1; loadAddr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, acyc[k], ok);
      check($sformatf("b2b_ack%0d", k), 64'(ok), 64'd1);
      @(posedge clk); #1;
      loadAddr = 32'(k + 1);
      if (k == 2) loadReq = 1'b0;
    end
    repeat (12) @(posedge clk);
    check("b2b_space01", 64'(acyc[1] - acyc[0]), 64'd7);
    check("b2b_space12", 64'(acyc[2] - acyc[1]), 64'd7);
    check("b2b_toggles", 64'(toggle_cnt - t0), 64'd3);
    check("b2b_count", 64'(lv_data.size() - n0), 64'd3);
    if (lv_data.size() - n0 == 3) begin
      for (int k = 0; k < 3; k++)
        check($sformatf("b2b_data%0d", k), 64'(lv_data[n0 + k]), 64'(rom_word(32'(k))));
    end

    // Reset mid-WAIT
    @(posedge clk); #1;
    fetchReq = 1'b1; fetchAddr = 32'h7;
    wait_ack(1'b0, a_cyc, ok);
    check("abort_ack", 64'(ok), 64'd1);
    @(posedge clk); #1 fetchReq = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    n0 = fvalid_cnt;
    @(posedge clk);
    @(negedge clk);
    check("abort_ctrl", 64'({fetchAck, loadAck, fetchValid, loadValid, romTrigger}), 64'd0);
    check("abort_data", 64'({fetchData, loadData}), 64'd0);
    check("abort_romaddr", 64'(romAddr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    check("abort_no_valid", 64'(fvalid_cnt - n0), 64'd0);
    txn(1'b0, 32'h10, "post_abort");

    // Random requests
    for (int i = 0; i < 20; i++) begin
      bit ld;
      logic [31:0] ad;
      ld = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 255));
      txn(ld, ad, $sformatf("rnd%0d", i));
    end
    repeat (3) @(posedge clk);
    check("toggle_eq_ack", 64'(toggle_cnt), 64'(ack_cnt));
    check("addr_stable", 64'(addr_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
